ex_hazard_sequencer: RTL and testbench
======================================

// Module: ex_hazard_sequencer
// PURPOSE
//  Hazard/forwarding controller for the RV32 execute stage. Drives the EX operand forwarding selects.
//  Detects load-use hazards, sequences multi-cycle EX ops (MUL/DIV) with an occupancy counter, and
//  issues pipeline stall/bubble controls. Sits beside instruction_execute; fed from ID, EX, MEM and WB regs.
// PARAMETERS
//  MC_LATENCY  4   cycles a multi-cycle op occupies EX (>=1; 1 = no stall)
//  CNT_W       8   width of occupancy counter (must hold MC_LATENCY-2)
// PORTS
//  clk           in  1   clock, rising edge
//  resetn        in  1   synchronous, active-high reset (1 = reset)
//  id_rs1,id_rs2 in  5   source regs of instr in ID
//  ex_rs1,ex_rs2 in  5   source regs of instr in EX
//  ex_rd         in  5   dest reg of instr in EX
//  ex_valid      in  1   EX holds a real instr
//  ex_memRead    in  1   EX instr is a load
//  ex_multicycle in  1   EX instr is multi-cycle
//  ex_ALUSrc     in  1   1 = op2 from rs2, 0 = imm
//  ex_kill       in  1   EX instr squashed (redirect); aborts multi-cycle op
//  mem_rd,wb_rd  in  5   dest regs in MEM / WB
//  mem_regWrite  in  1   MEM writes rd
//  wb_regWrite   in  1   WB writes rd
//  selOp1,selOp2 out 2   forwarding selects to EX muxes
//  stall_if      out 1   hold PC
//  stall_id      out 1   hold IF/ID reg
//  stall_ex      out 1   hold ID/EX reg
//  bubble_ex     out 1   insert NOP into ID/EX
//  bubble_mem    out 1   insert NOP into EX/MEM
//  mc_busy       out 1   multi-cycle op in progress
//  mc_done       out 1   1-cycle pulse: last EX cycle of multi-cycle op
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all outputs 0 while resetn=1.
//  Forwarding (combinational, 0 latency): selOp1 = FWD_ALU(2'b10) if mem_regWrite & mem_rd!=0 &
//   mem_rd==ex_rs1; else FWD_WB(2'b01) if wb_regWrite & wb_rd!=0 & wb_rd==ex_rs1; else FWD_RF(2'b00).
//   MEM beats WB on same rd. selOp2 uses the same rule on ex_rs2 only when ex_ALUSrc=1; else 2'b00.
//  Load-use (IDLE only): lu = ex_valid & ex_memRead & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//   lu -> stall_if=stall_id=bubble_ex=1 for that cycle. Single cycle; no state change.
//  FSM IDLE: if ex_valid & ex_multicycle & !ex_kill & MC_LATENCY>1:
//   assert stall_if/id/ex, bubble_mem; cnt<=MC_LATENCY-2; ->BUSY.
//   MC_LATENCY==1: op needs no stall; mc_done pulses same cycle; stay IDLE.
//  FSM BUSY: mc_busy=1. cnt!=0 -> stalls+bubble_mem asserted, cnt<=cnt-1.
//   cnt==0 -> stalls deasserted, mc_done=1, ->IDLE (op leaves EX next edge).
//   Total stall cycles = MC_LATENCY-1; EX occupancy = MC_LATENCY cycles.
//  ex_kill in BUSY (or with the IDLE trigger) -> no stalls that cycle, no mc_done, ->IDLE, cnt<=0.
//  Load-use is not evaluated in BUSY (EX frozen; MC op is never a load).
//  Reset mid-BUSY: returns to IDLE next edge, all stalls drop.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds outputs perf_lu_stalls[31:0] and perf_mc_stalls[31:0].
//   These count cycles with a load-use stall or a multi-cycle stall respectively.
//   Wrap at 2^32; cleared by reset.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  haz_pkg: fwd_sel_e {FWD_RF=2'b00,FWD_WB=2'b01,FWD_ALU=2'b10}, hz_state_e {IDLE,BUSY},
//   REG_ZERO=5'd0.
//  Sub-module haz_fwd_select (rs, mem_rd/wen, wb_rd/wen, en -> sel), instanced twice (op1, op2).
// TESTING
//  MEM rd=5 wen, WB rd=5 wen, ex_rs1=5 -> selOp1=2'b10; clear MEM wen -> 2'b01; rd=0 -> 2'b00.
//  ex_rs2=7 match MEM, ex_ALUSrc=0 -> selOp2=2'b00; ex_ALUSrc=1 -> 2'b10.
//  Load ex_rd=3, id_rs2=3 -> stall_if/id, bubble_ex high exactly 1 cycle; ex_rd=0 -> no stall.
//  MC op, MC_LATENCY=4 -> stalls 3 cycles, mc_done on cycle 4, mc_busy cycles 2-4, then IDLE.
//  ex_kill in 2nd BUSY cycle -> stalls drop that cycle, no mc_done, next MC op restarts full count.
//  resetn=1 mid-BUSY -> IDLE, outputs 0; with HAZ_PERF_CNT_EN, perf_mc_stalls=3 after one MC op.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared types and constants for the EX-stage hazard / forwarding controller.
package haz_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_ALU = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/haz_fwd_select.sv
// Operand forwarding select for one EX source operand.
// The MEM-stage result is younger than the WB-stage result, so MEM wins on an rd tie.
// Writes to x0 are never forwarded.
module haz_fwd_select
  import haz_pkg::*;
(
  input  logic       en,
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_wen,
  input  logic [4:0] wb_rd,
  input  logic       wb_wen,
  output logic [1:0] sel
);

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = mem_wen && (mem_rd != REG_ZERO) && (mem_rd == rs);
  assign wb_hit_s  = wb_wen  && (wb_rd  != REG_ZERO) && (wb_rd  == rs);

  // Priority pick of the forwarding source; disabled operands read the register file.
  always_comb begin
    sel = FWD_RF;
    if (!en) begin
      sel = FWD_RF;
    end else if (mem_hit_s) begin
      sel = FWD_ALU;
    end else if (wb_hit_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/ex_hazard_sequencer.sv
// Hazard / forwarding controller for the RV32 execute stage.
// Generates forwarding selects, load-use stalls and the multi-cycle (MUL/DIV) stall sequence.
// Optional feature macro: HAZ_PERF_CNT_EN adds perf_lu_stalls / perf_mc_stalls counters.
module ex_hazard_sequencer
  import haz_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_valid,
  input  logic       ex_memRead,
  input  logic       ex_multicycle,
  input  logic       ex_ALUSrc,
  input  logic       ex_kill,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_regWrite,
  input  logic       wb_regWrite,
  output logic [1:0] selOp1,
  output logic [1:0] selOp2,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       bubble_ex,
  output logic       bubble_mem,
  output logic       mc_busy,
  output logic       mc_done
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mc_stalls
`else
`endif
);

  // Counter preload on entering BUSY: BUSY lasts MC_LATENCY-1 cycles, the last one with cnt==0.
  localparam logic [CNT_W-1:0] MC_START = (MC_LATENCY > 1) ? CNT_W'(MC_LATENCY - 2) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e        state_r;
  hz_state_e        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             lu_stall_s;
  logic             mc_stall_s;
  logic             mc_done_s;
  logic             mc_trig_s;
  logic             lu_hit_s;

  // Forwarding is gated off during reset so every output reads 0.
  haz_fwd_select u_fwd_op1 (
    .en      (!resetn),
    .rs      (ex_rs1),
    .mem_rd  (mem_rd),
    .mem_wen (mem_regWrite),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_regWrite),
    .sel     (selOp1)
  );

  haz_fwd_select u_fwd_op2 (
    .en      (!resetn && ex_ALUSrc),
    .rs      (ex_rs2),
    .mem_rd  (mem_rd),
    .mem_wen (mem_regWrite),
    .wb_rd   (wb_rd),
    .wb_wen  (wb_regWrite),
    .sel     (selOp2)
  );

  assign lu_hit_s  = ex_valid && ex_memRead && (ex_rd != REG_ZERO) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign mc_trig_s = ex_valid && ex_multicycle && !ex_kill;

  // Next-state and stall decode; a kill aborts the op with no stall and no done pulse.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    lu_stall_s  = 1'b0;
    mc_stall_s  = 1'b0;
    mc_done_s   = 1'b0;
    if (resetn) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          lu_stall_s = lu_hit_s;
          if (mc_trig_s) begin
            if (MC_LATENCY > 1) begin
              mc_stall_s  = 1'b1;
              cnt_nxt_s   = MC_START;
              state_nxt_s = BUSY;
            end else begin
              mc_done_s = 1'b1;
            end
          end else begin
            cnt_nxt_s = CNT_ZERO;
          end
        end
        BUSY: begin
          if (ex_kill) begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = IDLE;
          end else if (cnt_r != CNT_ZERO) begin
            mc_stall_s = 1'b1;
            cnt_nxt_s  = cnt_r - CNT_ONE;
          end else begin
            mc_done_s   = 1'b1;
            state_nxt_s = IDLE;
          end
        end
        default: begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and occupancy counter registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign stall_if   = lu_stall_s || mc_stall_s;
  assign stall_id   = lu_stall_s || mc_stall_s;
  assign stall_ex   = mc_stall_s;
  assign bubble_ex  = lu_stall_s;
  assign bubble_mem = mc_stall_s;
  assign mc_busy    = !resetn && (state_r == BUSY);
  assign mc_done    = mc_done_s;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_r;
  logic [31:0] perf_mc_r;

  // Stall-cycle counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (resetn) begin
      perf_lu_r <= 32'd0;
      perf_mc_r <= 32'd0;
    end else begin
      perf_lu_r <= perf_lu_r + {31'd0, lu_stall_s};
      perf_mc_r <= perf_mc_r + {31'd0, mc_stall_s};
    end
  end

  assign perf_lu_stalls = resetn ? 32'd0 : perf_lu_r;
  assign perf_mc_stalls = resetn ? 32'd0 : perf_mc_r;
`else
`endif

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Directed self-checking bench for ex_hazard_sequencer (MC_LATENCY = 4).
module tb_ex_hazard_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_valid, ex_memRead, ex_multicycle, ex_ALUSrc, ex_kill;
  logic       mem_regWrite, wb_regWrite;
  logic [1:0] selOp1, selOp2;
  logic       stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, mc_busy, mc_done;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_mc_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_hazard_sequencer dut (
    .clk(clk), .resetn(resetn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_multicycle(ex_multicycle),
    .ex_ALUSrc(ex_ALUSrc), .ex_kill(ex_kill),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
    .selOp1(selOp1), .selOp2(selOp2),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .mc_busy(mc_busy), .mc_done(mc_done)
`ifdef HAZ_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_mc_stalls(perf_mc_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view of all stall/sequencing outputs: {stall_if,stall_id,stall_ex,bubble_ex,bubble_mem,mc_busy,mc_done}
  function automatic logic [31:0] ctl();
    return {25'd0, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, mc_busy, mc_done};
  endfunction

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0; ex_valid = 1'b0; ex_memRead = 1'b0;
    ex_multicycle = 1'b0; ex_ALUSrc = 1'b0; ex_kill = 1'b0;
    mem_regWrite = 1'b0; wb_regWrite = 1'b0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b1;
    // Reset: outputs held low even with hazard-triggering inputs present
    mem_rd = 5'd5; mem_regWrite = 1'b1; ex_rs1 = 5'd5;
    ex_valid = 1'b1; ex_multicycle = 1'b1;
    tick(); tick();
    #2;
    check("rst_sel1", {30'd0, selOp1}, 32'd0);
    check("rst_ctl", ctl(), 32'd0);
    tick();
    resetn = 1'b0;
    clear_inputs();
    #2;
    check("idle_ctl", ctl(), 32'd0);

    // Forwarding priority on op1
    mem_rd = 5'd5; mem_regWrite = 1'b1; wb_rd = 5'd5; wb_regWrite = 1'b1; ex_rs1 = 5'd5;
    #1; check("fwd1_mem", {30'd0, selOp1}, 32'd2);
    mem_regWrite = 1'b0;
    #1; check("fwd1_wb", {30'd0, selOp1}, 32'd1);
    mem_regWrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
    #1; check("fwd1_x0", {30'd0, selOp1}, 32'd0);

    // op2 forwarding gated by ex_ALUSrc
    mem_rd = 5'd7; mem_regWrite = 1'b1; ex_rs2 = 5'd7; ex_ALUSrc = 1'b0;
    #1; check("fwd2_imm", {30'd0, selOp2}, 32'd0);
    ex_ALUSrc = 1'b1;
    #1; check("fwd2_mem", {30'd0, selOp2}, 32'd2);
    wb_rd = 5'd7; wb_regWrite = 1'b1; mem_regWrite = 1'b0;
    #1; check("fwd2_wb", {30'd0, selOp2}, 32'd1);

    // Load-use: single-cycle stall, no state change
    tick();
    clear_inputs();
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3;
    #1; check("lu_hit", ctl(), 32'b1101000);
    tick();
    ex_memRead = 1'b0; ex_rd = 5'd9; id_rs2 = 5'd4;
    #1; check("lu_after", ctl(), 32'd0);
    ex_memRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1; check("lu_x0", ctl(), 32'd0);

    // Multi-cycle op, latency 4
    tick();
    clear_inputs();
    ex_valid = 1'b1; ex_multicycle = 1'b1;
    #1; check("mc_c1", ctl(), 32'b1110100);
    tick();
    #1; check("mc_c2", ctl(), 32'b1110110);
    tick();
    #1; check("mc_c3", ctl(), 32'b1110110);
    tick();
    #1; check("mc_c4", ctl(), 32'b0000011);
    tick();
    ex_multicycle = 1'b0; ex_valid = 1'b0;
    #1; check("mc_idle", ctl(), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("perf_lu", perf_lu_stalls, 32'd1);
    check("perf_mc", perf_mc_stalls, 32'd3);
`endif

    // Kill in 2nd BUSY cycle, then a fresh op restarts the full count
    ex_valid = 1'b1; ex_multicycle = 1'b1;
    tick();
    tick();
    ex_kill = 1'b1;
    #1;
    check("kill_stall", {31'd0, stall_if}, 32'd0);
    check("kill_done", {31'd0, mc_done}, 32'd0);
    check("kill_bub", {31'd0, bubble_mem}, 32'd0);
    tick();
    ex_kill = 1'b0;
    #1; check("re_c1", ctl(), 32'b1110100);
    tick();
    #1; check("re_c2", ctl(), 32'b1110110);
    tick();
    #1; check("re_c3", ctl(), 32'b1110110);
    tick();
    #1; check("re_c4", ctl(), 32'b0000011);
    tick();
    ex_multicycle = 1'b0;

    // Reset in the middle of BUSY
    ex_multicycle = 1'b1;
    tick();
    #1; check("rb_busy", ctl(), 32'b1110110);
    resetn = 1'b1;
    #1; check("rb_gated", ctl(), 32'd0);
    tick();
    resetn = 1'b0; ex_multicycle = 1'b0; ex_valid = 1'b0;
    #1; check("rb_idle", ctl(), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("rb_perf", perf_mc_stalls, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
